aclk_display_ctrl: RTL and testbench
====================================

# aclk_display_ctrl

Parametrised, registered successor to the alarm clock's digit display stage. It drives NUM_DIGITS ASCII display characters from one of three BCD sources: current time, alarm time or keypad entry. It also owns the alarm state machine: edge-triggered match detection, ring timeout, blinking and optional snooze. It sits between the time/alarm/key registers and the LCD interface.

## Interface
- NUM_DIGITS, 4: number of BCD digits per time value (≥1).
- RING_SECS, 60: `tick` pulses before an unacknowledged alarm stops by itself (≥1).
- SNOOZE_SECS, 300: `tick` pulses spent in SNOOZE (≥1; used only with ACLK_SNOOZE_EN).
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-second strobe, one `clock` cycle wide.
- `current_time`  in  4*NUM_DIGITS  BCD current time; digit 0 is the LS nibble.
- `alarm_time`  in  4*NUM_DIGITS  BCD alarm setting.
- `key_time`  in  4*NUM_DIGITS  BCD keypad entry.
- `show_new_time`  in  1  display `key_time`; highest priority.
- `show_a`  in  1  display `alarm_time`.
- `alarm_en`  in  1  arms match detection.
- `alarm_off`  in  1  pulse; silences the alarm.
- `snooze`  in  1  pulse; snooze request (ignored without ACLK_SNOOZE_EN).
- `display`  out  8*NUM_DIGITS  ASCII characters; digit i occupies bits [8i+7:8i].
- `sound_alarm`  out  1  high while state is RINGING.

## Operation
- Source select: `show_new_time` takes priority, then `show_a`, then `current_time`.
- Encoding per digit: BCD 0–9 → 8'h30+d. BCD 10–15 → 8'h45 ('E'). Blank → 8'h20.
- Match: `eq` is high when all NUM_DIGITS of `current_time` equal `alarm_time`. `eq_q` is a register holding the previous `eq`. The trigger is `match_rise = eq & ~eq_q & alarm_en`, so the alarm fires once per match window, not continuously.
- State machine states: IDLE, RINGING, SNOOZE.
  - IDLE → RINGING on `match_rise`. Loads `ring_cnt` = RING_SECS.
  - RINGING → IDLE on `alarm_off`, or on a `tick` when `ring_cnt`==1. Otherwise each `tick` decrements `ring_cnt`.
  - RINGING → SNOOZE on `snooze` (macro only). Loads `snz_cnt` = SNOOZE_SECS.
  - SNOOZE → RINGING on a `tick` when `snz_cnt`==1. Reloads `ring_cnt`. Otherwise each `tick` decrements `snz_cnt`.
  - SNOOZE → IDLE on `alarm_off`.
- Priority in the same cycle: `alarm_off` beats `snooze`, and both beat timeout.
- `match_rise` while RINGING or SNOOZE is ignored; counters are not reloaded.
- `alarm_en` low forces IDLE on the next edge from any state.
- Blink: `blink_ph` toggles on each `tick` while RINGING and clears otherwise. When `blink_ph`=1 and the current-time source is selected, all digits show 8'h20. Keypad and alarm views never blink.
- Counter widths: $clog2(RING_SECS+1) and $clog2(SNOOZE_SECS+1), unsigned.

## Timing
- `display` is registered: latency is 1 cycle from any input change.
- `sound_alarm` is decoded from the state register. It rises 1 cycle after the edge at which `match_rise` is sampled.
- `alarm_off` drops `sound_alarm` on the next edge.
- Reset values: state = IDLE; `eq_q` = 1, so a match present at reset does not fire; `ring_cnt`, `snz_cnt` and `blink_ph` = 0; `display` = all 8'h20; `sound_alarm` = 0.
- Reset asserted mid-ring: the state machine returns to IDLE immediately (asynchronously). After release, the alarm does not re-fire until `eq` has fallen and risen again.
- `tick` coincident with a state entry: the counter loads and does not decrement in that cycle.

## Configuration
- `ACLK_SNOOZE_EN` defined: the SNOOZE state, `snz_cnt` and the `snooze` input are functional.
- Undefined: `snooze` is ignored, the SNOOZE state and `snz_cnt` are not synthesised, and SNOOZE_SECS is unused. RINGING exits only on `alarm_off`, timeout or `alarm_en` low.

## Structure
- Shared package `aclk_pkg`:
  - state enum `aclk_alm_state_t` {IDLE, RINGING, SNOOZE};
  - constants `ASCII_ZERO`=8'h30, `ASCII_ERR`=8'h45, `ASCII_BLANK`=8'h20.
- Sub-module `aclk_digit_encode`: combinational BCD→ASCII with a blank input. Instantiated NUM_DIGITS times via generate.

## Test plan
- Reset with `current_time`=`alarm_time`=12:00 and `alarm_en`=1 → `display`=all 8'h20; `sound_alarm` stays 0 after release.
- `current_time` steps 11:59→12:00 with alarm 12:00 and `alarm_en`=1 → `sound_alarm` goes high 1 cycle after the step. Digits blink on alternate ticks. After 60 ticks `sound_alarm`=0.
- Ring, then `alarm_off` together with `snooze` in the same cycle → IDLE next cycle. With ACLK_SNOOZE_EN: `snooze` alone → silent for 300 ticks, then ringing resumes.
- `show_new_time`=1 and `show_a`=1 with key=0,9,3,7 → `display`=8'h37_33_39_30 (digit 3 down to digit 0), with no blanking while RINGING.
- BCD digit 4'hB in `current_time` → that digit shows 8'h45.
- NUM_DIGITS=6 with an HH:MM:SS match → single trigger, full 48-bit `display` correct.

Source files
------------

// File: rtl/aclk_display_ctrl_pkg.sv
// Shared types and constants for the alarm-clock display/alarm controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control; declarations only).
package aclk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } aclk_alm_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ERR   = 8'h45;
  localparam logic [7:0] ASCII_BLANK = 8'h20;

endpackage

// File: rtl/aclk_display_ctrl_if.sv
// Bundle of the time/alarm/key buses, control strobes and display outputs.
// Latency: n/a (wiring only).
// Backpressure: none; slave samples every cycle.
// Ports: master drives tick/times/controls and reads display/sound_alarm;
//        slave (the controller) is the opposite side.
interface aclk_display_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] current_time;
  logic [4*NUM_DIGITS-1:0] alarm_time;
  logic [4*NUM_DIGITS-1:0] key_time;
  logic                    show_new_time;
  logic                    show_a;
  logic                    alarm_en;
  logic                    alarm_off;
  logic                    snooze;
  logic [8*NUM_DIGITS-1:0] display;
  logic                    sound_alarm;

  modport master (
    output tick, current_time, alarm_time, key_time,
    output show_new_time, show_a, alarm_en, alarm_off, snooze,
    input  display, sound_alarm
  );

  modport slave (
    input  tick, current_time, alarm_time, key_time,
    input  show_new_time, show_a, alarm_en, alarm_off, snooze,
    output display, sound_alarm
  );
endinterface

// File: rtl/aclk_display_ctrl_digit_encode.sv
// BCD digit to ASCII character, with forced blank.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd (4b digit), blank (force space), ascii (8b character).
module aclk_digit_encode
  import aclk_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_BLANK;
    if (!blank) begin
      // Non-decimal nibbles are shown as 'E' so corrupt time is visible.
      ascii = (bcd <= 4'd9) ? (ASCII_ZERO + {4'h0, bcd}) : ASCII_ERR;
    end
  end

endmodule

// File: rtl/aclk_display_ctrl.sv
// Alarm-clock display driver plus alarm FSM (match edge detect, ring timeout, blink, snooze).
// Latency: display 1 cycle from any input; sound_alarm 1 cycle after match_rise is sampled.
// Backpressure: none; all inputs sampled every clock. Snooze needs macro ACLK_SNOOZE_EN.
// Ports: clock, reset_n (async active-low), bus (aclk_display_ctrl_if.slave).
module aclk_display_ctrl
  import aclk_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic                clock,
  input  logic                reset_n,
  aclk_display_ctrl_if.slave  bus
);

  localparam int RW = $clog2(RING_SECS + 1);

  aclk_alm_state_t state, state_nxt;
  logic [RW-1:0]   ring_cnt, ring_nxt;
  logic            blink_ph, blink_nxt;
  logic            eq, eq_q, match_rise;

`ifdef ACLK_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  logic [SW-1:0]   snz_cnt, snz_nxt;
`endif

  // Rising edge of the match only, so a held match fires once.
  assign eq         = (bus.current_time == bus.alarm_time);
  assign match_rise = eq & ~eq_q & bus.alarm_en;

  always_comb begin
    state_nxt = state;
    ring_nxt  = ring_cnt;
    blink_nxt = 1'b0;
`ifdef ACLK_SNOOZE_EN
    snz_nxt   = snz_cnt;
`endif
    if (!bus.alarm_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (match_rise) begin
            state_nxt = RINGING;
            ring_nxt  = RW'(RING_SECS);
          end
        end
        RINGING: begin
          blink_nxt = blink_ph ^ bus.tick;
          if (bus.alarm_off) begin
            state_nxt = IDLE;
            blink_nxt = 1'b0;
`ifdef ACLK_SNOOZE_EN
          end else if (bus.snooze) begin
            state_nxt = SNOOZE;
            snz_nxt   = SW'(SNOOZE_SECS);
            blink_nxt = 1'b0;
`endif
          end else if (bus.tick) begin
            if (ring_cnt == RW'(1)) begin
              state_nxt = IDLE;
              blink_nxt = 1'b0;
            end else begin
              ring_nxt = ring_cnt - RW'(1);
            end
          end
        end
`ifdef ACLK_SNOOZE_EN
        SNOOZE: begin
          if (bus.alarm_off) begin
            state_nxt = IDLE;
          end else if (bus.tick) begin
            if (snz_cnt == SW'(1)) begin
              state_nxt = RINGING;
              ring_nxt  = RW'(RING_SECS);
            end else begin
              snz_nxt = snz_cnt - SW'(1);
            end
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ring_cnt <= '0;
      blink_ph <= 1'b0;
      // Start as "already matching" so a match present at reset cannot fire.
      eq_q     <= 1'b1;
`ifdef ACLK_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_nxt;
      blink_ph <= blink_nxt;
      eq_q     <= eq;
`ifdef ACLK_SNOOZE_EN
      snz_cnt  <= snz_nxt;
`endif
    end
  end

  assign bus.sound_alarm = (state == RINGING);

  // Source select and per-digit encode; only the live clock view blinks.
  logic [4*NUM_DIGITS-1:0] sel_time;
  logic [8*NUM_DIGITS-1:0] disp_nxt;
  logic                    blank_all;

  assign sel_time  = bus.show_new_time ? bus.key_time :
                     bus.show_a        ? bus.alarm_time : bus.current_time;
  assign blank_all = blink_ph & ~bus.show_new_time & ~bus.show_a;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    aclk_digit_encode u_enc (
      .bcd   (sel_time[4*gi +: 4]),
      .blank (blank_all),
      .ascii (disp_nxt[8*gi +: 8])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.display <= {NUM_DIGITS{ASCII_BLANK}};
    end else begin
      bus.display <= disp_nxt;
    end
  end

endmodule

// File: tb/tb_aclk_display_ctrl.sv
// Self-checking bench for aclk_display_ctrl (4-digit and 6-digit instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_aclk_display_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  aclk_display_ctrl_if #(.NUM_DIGITS(4)) if4 ();
  aclk_display_ctrl_if #(.NUM_DIGITS(6)) if6 ();

  aclk_display_ctrl #(.NUM_DIGITS(4), .RING_SECS(60), .SNOOZE_SECS(300)) dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if4)
  );

  aclk_display_ctrl #(.NUM_DIGITS(6), .RING_SECS(60), .SNOOZE_SECS(300)) dut6 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if6)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sn;
    logic        sa;
    logic [15:0] cur;
    logic [15:0] alm;
    logic [15:0] key;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:6];
  logic [31:0] exp_q [$];

  // One tick pulse, then one idle cycle so any display effect is visible.
  task automatic do_tick();
    @(negedge clock) if4.tick = 1'b1;
    @(negedge clock) if4.tick = 1'b0;
    @(negedge clock);
  endtask

  // Make eq fall then rise on the 4-digit instance; expect ringing one cycle later.
  task automatic trigger4(input string name);
    @(negedge clock) if4.current_time = 16'h1159;
    @(negedge clock) if4.current_time = 16'h1200;
    #1 chk({name, "_pre"}, {63'd0, if4.sound_alarm}, 64'd0);
    @(negedge clock);
    chk(name, {63'd0, if4.sound_alarm}, 64'd1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 32'h31323334};
    vecs[1] = '{1'b0, 1'b1, 16'h1234, 16'h0659, 16'h0000, 32'h30363539};
    vecs[2] = '{1'b1, 1'b0, 16'h1234, 16'h0659, 16'h7390, 32'h37333930};
    vecs[3] = '{1'b1, 1'b1, 16'h1234, 16'h0659, 16'h7390, 32'h37333930};
    vecs[4] = '{1'b0, 1'b0, 16'h1B00, 16'h0659, 16'h7390, 32'h31453030};
    vecs[5] = '{1'b0, 1'b0, 16'hFA99, 16'h0659, 16'h7390, 32'h45453939};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 32'h30303030};

    if4.tick = 0; if4.current_time = 16'h1200; if4.alarm_time = 16'h1200;
    if4.key_time = 0; if4.show_new_time = 0; if4.show_a = 0;
    if4.alarm_en = 1; if4.alarm_off = 0; if4.snooze = 0;
    if6.tick = 0; if6.current_time = 24'h000000; if6.alarm_time = 24'h235959;
    if6.key_time = 0; if6.show_new_time = 0; if6.show_a = 0;
    if6.alarm_en = 0; if6.alarm_off = 0; if6.snooze = 0;

    // Reset with a standing match.
    repeat (3) @(negedge clock);
    chk("rst_display", {32'd0, if4.display}, {32'd0, 32'h20202020});
    chk("rst_sound", {63'd0, if4.sound_alarm}, 64'd0);
    chk("rst_display6", {16'd0, if6.display}, {16'd0, 48'h202020202020});
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst_no_fire", {63'd0, if4.sound_alarm}, 64'd0);

    // Table-driven display vectors through a one-deep scoreboard.
    if4.alarm_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if4.show_new_time = vecs[i].sn;
      if4.show_a        = vecs[i].sa;
      if4.current_time  = vecs[i].cur;
      if4.alarm_time    = vecs[i].alm;
      if4.key_time      = vecs[i].key;
      exp_q.push_back(vecs[i].exp);
      @(negedge clock);
      chk($sformatf("vec%0d", i), {32'd0, if4.display}, {32'd0, exp_q.pop_front()});
    end
    if4.show_new_time = 0; if4.show_a = 0;
    if4.alarm_time = 16'h1200; if4.current_time = 16'h1159; if4.key_time = 16'h7390;
    @(negedge clock) if4.alarm_en = 1'b1;

    // Ring, blink, keypad view unblanked, timeout after 60 ticks.
    trigger4("ring_rise");
    chk("ring_disp", {32'd0, if4.display}, {32'd0, 32'h31323030});
    do_tick();
    chk("blink_on", {32'd0, if4.display}, {32'd0, 32'h20202020});
    if4.show_new_time = 1'b1;
    @(negedge clock);
    chk("key_noblink", {32'd0, if4.display}, {32'd0, 32'h37333930});
    if4.show_new_time = 1'b0;
    do_tick();
    chk("blink_off", {32'd0, if4.display}, {32'd0, 32'h31323030});
    for (int i = 0; i < 57; i++) do_tick();
    chk("ring_59", {63'd0, if4.sound_alarm}, 64'd1);
    do_tick();
    chk("ring_timeout", {63'd0, if4.sound_alarm}, 64'd0);
    repeat (3) @(negedge clock);
    chk("no_refire", {63'd0, if4.sound_alarm}, 64'd0);

    // alarm_off together with snooze: off wins.
    trigger4("ring2_rise");
    if4.alarm_off = 1'b1; if4.snooze = 1'b1;
    @(negedge clock);
    if4.alarm_off = 1'b0; if4.snooze = 1'b0;
    chk("off_beats_snooze", {63'd0, if4.sound_alarm}, 64'd0);

    // Asynchronous reset mid-ring, no re-fire until the match re-rises.
    trigger4("ring3_rise");
    #2 reset_n = 1'b0;
    #1 chk("async_rst", {63'd0, if4.sound_alarm}, 64'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_quiet", {63'd0, if4.sound_alarm}, 64'd0);
    trigger4("ring4_rise");
    if4.alarm_en = 1'b0;
    @(negedge clock);
    chk("en_low_idle", {63'd0, if4.sound_alarm}, 64'd0);
    if4.alarm_en = 1'b1;

`ifdef ACLK_SNOOZE_EN
    trigger4("ring5_rise");
    if4.snooze = 1'b1;
    @(negedge clock) if4.snooze = 1'b0;
    chk("snooze_quiet", {63'd0, if4.sound_alarm}, 64'd0);
    for (int i = 0; i < 299; i++) do_tick();
    chk("snooze_299", {63'd0, if4.sound_alarm}, 64'd0);
    do_tick();
    chk("snooze_resume", {63'd1, if4.sound_alarm} & 64'd1, 64'd1);
    if4.alarm_off = 1'b1;
    @(negedge clock) if4.alarm_off = 1'b0;
`endif

    // Six-digit HH:MM:SS match.
    if6.current_time = 24'h235958; if6.alarm_en = 1'b1;
    @(negedge clock) if6.current_time = 24'h235959;
    @(negedge clock);
    chk("d6_ring", {63'd0, if6.sound_alarm}, 64'd1);
    chk("d6_display", {16'd0, if6.display}, {16'd0, 48'h323335393539});
    if6.alarm_off = 1'b1;
    @(negedge clock) if6.alarm_off = 1'b0;
    chk("d6_off", {63'd0, if6.sound_alarm}, 64'd0);
    repeat (5) @(negedge clock);
    chk("d6_single", {63'd0, if6.sound_alarm}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
